// File: rtl/axi4lite_pkg.sv
// Shared definitions for the AXI4-Lite memory slave: response codes and FSM state types.
package axi4lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_COLLECT = 1'b0,
    W_RESP    = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi4lite_bytemem.sv
// DEPTH x 128-bit storage with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module axi4lite_bytemem #(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [127:0]  wdata,
  input  logic [15:0]   wstrb,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [127:0]  rdata
);

  logic [127:0] mem [DEPTH];

  // Read and write on the same edge to the same word returns the old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 16; i++) begin
        if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi4lite_slave_mem.sv
// AXI4-Lite slave backed by a byte-enabled 128-bit memory; independent read and write FSMs.
//   state     | meaning
//   W_COLLECT | gathering AW and W (either order); commits when both are held
//   W_RESP    | write committed, bvalid high until B handshake
//   R_IDLE    | arready high, waiting for an address
//   R_DATA    | rvalid high, rdata/rresp held until R handshake
module axi4lite_slave_mem
  import axi4lite_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  awaddr,
  input  logic         awvalid,
  output logic         awready,
  input  logic [127:0] wdata,
  input  logic [15:0]  wstrb,
  input  logic         wvalid,
  output logic         wready,
  output logic [1:0]   bresp,
  output logic         bvalid,
  input  logic         bready,
  input  logic [31:0]  araddr,
  input  logic         arvalid,
  output logic         arready,
  output logic [127:0] rdata,
  output logic [1:0]   rresp,
  output logic         rvalid,
  input  logic         rready
);

  localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SPAN = 32'(DEPTH * 16);

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  logic         aw_held, w_held;
  logic [31:0]  aw_addr_q;
  logic [127:0] w_data_q;
  logic [15:0]  w_strb_q;
  logic [1:0]   bresp_q, rresp_q;
  logic         rd_zero_q;

  logic         aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic         wr_commit, wr_in_range, rd_in_range;
  logic [31:0]  wr_addr, wr_off, rd_off;
  logic [127:0] wr_data;
  logic [15:0]  wr_strb;
  logic [127:0] mem_rdata;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign ar_hs = arvalid & arready;
  assign b_hs  = bvalid & bready;
  assign r_hs  = rvalid & rready;

  // Each channel's payload comes from its holding register if it arrived earlier.
  assign wr_addr = aw_held ? aw_addr_q : awaddr;
  assign wr_data = w_held  ? w_data_q  : wdata;
  assign wr_strb = w_held  ? w_strb_q  : wstrb;
  assign wr_commit = !rst && (wr_state == W_COLLECT) &&
                     (aw_held || aw_hs) && (w_held || w_hs);

  assign wr_off      = wr_addr - BASE_ADDR;
  assign rd_off      = araddr - BASE_ADDR;
  assign wr_in_range = (wr_addr >= BASE_ADDR) && (wr_off < SPAN);
  assign rd_in_range = (araddr >= BASE_ADDR) && (rd_off < SPAN);

  // Write FSM
  always_ff @(posedge clk) begin
    if (rst) wr_state <= W_COLLECT;
    else     wr_state <= wr_state_nxt;
  end

  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      W_COLLECT: if (wr_commit) wr_state_nxt = W_RESP;
      W_RESP:    if (b_hs)      wr_state_nxt = W_COLLECT;
      default:                  wr_state_nxt = W_COLLECT;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (wr_state)
      W_COLLECT: begin
        awready = !rst && !aw_held;
        wready  = !rst && !w_held;
      end
      W_RESP:  bvalid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
    end else if (wr_commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
    end
  end

  assign bresp = bresp_q;

  // Read FSM
  always_ff @(posedge clk) begin
    if (rst) rd_state <= R_IDLE;
    else     rd_state <= rd_state_nxt;
  end

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs) rd_state_nxt = R_DATA;
      R_DATA:  if (r_hs)  rd_state_nxt = R_IDLE;
      default:            rd_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    arready = 1'b0;
    rvalid  = 1'b0;
    case (rd_state)
      R_IDLE:  arready = !rst;
      R_DATA:  rvalid  = 1'b1;
      default: ;
    endcase
  end

  // Out-of-range and post-reset reads mask the memory port to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rresp_q   <= RESP_OKAY;
      rd_zero_q <= 1'b1;
    end else if (ar_hs) begin
      rresp_q   <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      rd_zero_q <= !rd_in_range;
    end
  end

  assign rdata = rd_zero_q ? '0 : mem_rdata;
  assign rresp = rresp_q;

  axi4lite_bytemem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_commit && wr_in_range),
    .waddr (wr_off[AW+3:4]),
    .wdata (wr_data),
    .wstrb (wr_strb),
    .re    (ar_hs && rd_in_range),
    .raddr (rd_off[AW+3:4]),
    .rdata (mem_rdata)
  );

endmodule

// File: doc/axi4lite_slave_mem.md
AXI4LITE_SLAVE_MEM -- requirements
Module: axi4lite_slave_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of 128-bit storage words (power of two, 2..1024).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of word 0 (aligned to DEPTH*16).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have AW ports: awaddr in 32, awvalid in 1, awready out 1.
REQ-006 SHALL have W ports: wdata in 128, wstrb in 16, wvalid in 1, wready out 1.
REQ-007 SHALL have B ports: bresp out 2, bvalid out 1, bready in 1.
REQ-008 SHALL have AR ports: araddr in 32, arvalid in 1, arready out 1.
REQ-009 SHALL have R ports: rdata out 128, rresp out 2, rvalid out 1, rready in 1.

Function
REQ-010 SHALL treat a handshake as valid&ready high at a rising clk edge; once asserted, outputs SHALL stay stable until their handshake.
REQ-011 SHALL decode word index = (addr - BASE_ADDR) >> 4; addr[3:0] ignored; addr < BASE_ADDR or >= BASE_ADDR + DEPTH*16 is out of range.
REQ-012 Write FSM SHALL use states W_COLLECT and W_RESP.
REQ-013 In W_COLLECT: awready=1 while no address is held, wready=1 while no data is held; AW and W are accepted in either order or in the same cycle.
REQ-014 On the edge where both are held, the block SHALL commit the write, enter W_RESP, and present bvalid=1 in the next cycle.
REQ-015 Commit SHALL update byte i of the word only where wstrb[i]=1; out-of-range writes SHALL modify nothing.
REQ-016 bresp SHALL be 2'b00 (OKAY) in range and 2'b10 (SLVERR) out of range.
REQ-017 In W_RESP: awready=wready=0; on the bvalid&bready edge, return to W_COLLECT with held flags cleared (awready=wready=1 the next cycle).
REQ-018 Read FSM SHALL use states R_IDLE (arready=1, rvalid=0) and R_DATA (arready=0, rvalid=1).
REQ-019 On the AR handshake edge, the block SHALL register rdata from storage and enter R_DATA; rvalid=1 the next cycle (one-cycle latency).
REQ-020 Out-of-range reads SHALL return rdata=0 and rresp=2'b10; in range, rresp=2'b00.
REQ-021 In R_DATA, rdata and rresp SHALL be held until the rvalid&rready edge, then the block SHALL return to R_IDLE.
REQ-022 Read and write paths SHALL be independent and may be active concurrently.
REQ-023 If a write commits on the same edge as an AR handshake to the same word, the read SHALL return the pre-write data.
REQ-024 Maximum throughput SHALL be one write per 2 cycles and one read per 2 cycles.

Reset
REQ-025 While rst=1 at an edge: both FSMs SHALL go to their idle states, held flags SHALL clear, bvalid=rvalid=0, bresp=rresp=0, rdata=0, and awready=wready=arready=0.
REQ-026 In the first cycle after rst deasserts, awready=wready=arready=1.
REQ-027 Storage contents SHALL NOT be reset; a transaction in flight at reset SHALL be dropped without a response.

Structure
REQ-028 Package axi4lite_pkg SHALL hold the response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10, plus the write-state and read-state enum typedefs.
REQ-029 Storage SHALL be a sub-module axi4lite_bytemem: DEPTH x 128 bits, 16 byte-enables, one write port, one registered read port.

Verification
REQ-030 AW and W presented in the same cycle: awaddr=0x10, wdata=0x0123..EF (pattern), wstrb=16'hFFFF, bready=1 -> bvalid the next cycle with bresp=00; a read at 0x10 then returns the pattern with rresp=00.
REQ-031 W presented 3 cycles before AW, wstrb=16'h000F, wdata low word 0xDEADBEEF, over word 1 previously all 0xFF -> only bytes 0-3 change.
REQ-032 Write to 0x100 with DEPTH=16 -> bresp=10 and no word changes. Read of 0x100 -> rdata=0, rresp=10.
REQ-033 bready held 0 for 5 cycles -> bvalid and bresp stable, awready=wready=0 throughout. Likewise rready held 0 -> rdata stable.
REQ-034 Same-edge write commit and AR handshake to word 2, old value 0xA, new value 0xB -> R returns 0xA; the next read returns 0xB.
REQ-035 rst asserted while bvalid=1 -> the cycle after reset has bvalid=0 and awready=1, and previously written memory contents are preserved.
